// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order commit ROB with 2-wide registered retire into the ARF
// Entries are allocated at tail, completed out of order, and retired from head in program order.
module reorder_buffer #(
   parameter int ROB_DEPTH = 16,
   parameter int ROB_IDX   = 4,
   parameter int PR_SIZE   = 6,
   parameter int AR_SIZE   = 6
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               alloc_valid,
   output logic               alloc_ready,
   input  logic               alloc_has_dest,
   input  logic [PR_SIZE-1:0] alloc_preg,
   input  logic [AR_SIZE-1:0] alloc_areg,
   output logic [ROB_IDX-1:0] alloc_idx,
   input  logic               cmp0_valid,
   input  logic [ROB_IDX-1:0] cmp0_idx,
   input  logic [31:0]        cmp0_data,
   input  logic               cmp1_valid,
   input  logic [ROB_IDX-1:0] cmp1_idx,
   input  logic [31:0]        cmp1_data,
   input  logic               flush,
   output logic               ret_en,
   output logic [PR_SIZE-1:0] ret_preg1,
   output logic [31:0]        ret_data1,
   output logic [AR_SIZE-1:0] ret_areg1,
   output logic [PR_SIZE-1:0] ret_preg2,
   output logic [31:0]        ret_data2,
   output logic [AR_SIZE-1:0] ret_areg2,
   output logic [1:0]         ret_count,
   output logic [ROB_IDX:0]   rob_count,
   output logic               rob_empty
);

   logic [ROB_DEPTH-1:0]              valid_q, valid_d;
   logic [ROB_DEPTH-1:0]              done_q, done_d;
   logic [ROB_DEPTH-1:0]              has_dest_q, has_dest_d;
   logic [ROB_DEPTH-1:0][PR_SIZE-1:0] preg_q, preg_d;
   logic [ROB_DEPTH-1:0][AR_SIZE-1:0] areg_q, areg_d;
   logic [ROB_DEPTH-1:0][31:0]        data_q, data_d;
   logic [ROB_IDX-1:0]                head_q, head_d, tail_q, tail_d;
   logic [ROB_IDX:0]                  rob_count_q, rob_count_d;

   logic               ret_en_q, ret_en_d;
   logic [PR_SIZE-1:0] ret_preg1_q, ret_preg1_d, ret_preg2_q, ret_preg2_d;
   logic [31:0]        ret_data1_q, ret_data1_d, ret_data2_q, ret_data2_d;
   logic [AR_SIZE-1:0] ret_areg1_q, ret_areg1_d, ret_areg2_q, ret_areg2_d;
   logic [1:0]         ret_count_q, ret_count_d;

   logic [ROB_IDX-1:0] head_p1;
   logic               ret1, ret2, alloc_fire;
   logic [1:0]         retired;

   // Occupancy is sampled at cycle start, so a same-cycle retire never frees a slot for alloc.
   assign alloc_ready = (rob_count_q < (ROB_IDX+1)'(ROB_DEPTH)) && !flush;
   assign alloc_idx   = tail_q;
   assign alloc_fire  = alloc_valid && alloc_ready;
   assign head_p1     = head_q + ROB_IDX'(1);
   assign ret1        = valid_q[head_q] && done_q[head_q];
   assign ret2        = ret1 && valid_q[head_p1] && done_q[head_p1];
   assign retired     = {1'b0, ret1} + {1'b0, ret2};

   always_comb begin
      valid_d     = valid_q;
      done_d      = done_q;
      has_dest_d  = has_dest_q;
      preg_d      = preg_q;
      areg_d      = areg_q;
      data_d      = data_q;
      head_d      = head_q;
      tail_d      = tail_q;
      rob_count_d = rob_count_q;
      ret_en_d    = 1'b0;
      ret_count_d = 2'd0;
      ret_preg1_d = '0;
      ret_data1_d = '0;
      ret_areg1_d = '0;
      ret_preg2_d = '0;
      ret_data2_d = '0;
      ret_areg2_d = '0;
      if (flush) begin
         valid_d     = '0;
         done_d      = '0;
         head_d      = '0;
         tail_d      = '0;
         rob_count_d = '0;
      end else begin
         // Port 1 first so port 0 overrides it when both name the same entry.
         if (cmp1_valid && valid_q[cmp1_idx]) begin
            done_d[cmp1_idx] = 1'b1;
            data_d[cmp1_idx] = cmp1_data;
         end
         if (cmp0_valid && valid_q[cmp0_idx]) begin
            done_d[cmp0_idx] = 1'b1;
            data_d[cmp0_idx] = cmp0_data;
         end
         if (ret1) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            ret_en_d        = 1'b1;
            ret_preg1_d     = has_dest_q[head_q] ? preg_q[head_q] : '0;
            ret_data1_d     = data_q[head_q];
            ret_areg1_d     = areg_q[head_q];
         end
         if (ret2) begin
            valid_d[head_p1] = 1'b0;
            done_d[head_p1]  = 1'b0;
            ret_preg2_d      = has_dest_q[head_p1] ? preg_q[head_p1] : '0;
            ret_data2_d      = data_q[head_p1];
            ret_areg2_d      = areg_q[head_p1];
         end
         if (alloc_fire) begin
            valid_d[tail_q]    = 1'b1;
            done_d[tail_q]     = 1'b0;
            has_dest_d[tail_q] = alloc_has_dest;
            preg_d[tail_q]     = alloc_preg;
            areg_d[tail_q]     = alloc_areg;
            tail_d             = tail_q + ROB_IDX'(1);
         end
         ret_count_d = retired;
         head_d      = head_q + ROB_IDX'(retired);
         rob_count_d = rob_count_q + (ROB_IDX+1)'(alloc_fire) - (ROB_IDX+1)'(retired);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q     <= '0;
         done_q      <= '0;
         has_dest_q  <= '0;
         preg_q      <= '0;
         areg_q      <= '0;
         data_q      <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         rob_count_q <= '0;
         ret_en_q    <= 1'b0;
         ret_count_q <= '0;
         ret_preg1_q <= '0;
         ret_data1_q <= '0;
         ret_areg1_q <= '0;
         ret_preg2_q <= '0;
         ret_data2_q <= '0;
         ret_areg2_q <= '0;
      end else begin
         valid_q     <= valid_d;
         done_q      <= done_d;
         has_dest_q  <= has_dest_d;
         preg_q      <= preg_d;
         areg_q      <= areg_d;
         data_q      <= data_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         rob_count_q <= rob_count_d;
         ret_en_q    <= ret_en_d;
         ret_count_q <= ret_count_d;
         ret_preg1_q <= ret_preg1_d;
         ret_data1_q <= ret_data1_d;
         ret_areg1_q <= ret_areg1_d;
         ret_preg2_q <= ret_preg2_d;
         ret_data2_q <= ret_data2_d;
         ret_areg2_q <= ret_areg2_d;
      end
   end

   assign ret_en    = ret_en_q;
   assign ret_count = ret_count_q;
   assign ret_preg1 = ret_preg1_q;
   assign ret_data1 = ret_data1_q;
   assign ret_areg1 = ret_areg1_q;
   assign ret_preg2 = ret_preg2_q;
   assign ret_data2 = ret_data2_q;
   assign ret_areg2 = ret_areg2_q;
   assign rob_count = rob_count_q;
   assign rob_empty = (rob_count_q == '0);

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - directed scenario bench for reorder_buffer
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        alloc_valid = 1'b0;
   logic        alloc_ready;
   logic        alloc_has_dest = 1'b0;
   logic [5:0]  alloc_preg = '0;
   logic [5:0]  alloc_areg = '0;
   logic [3:0]  alloc_idx;
   logic        cmp0_valid = 1'b0;
   logic [3:0]  cmp0_idx = '0;
   logic [31:0] cmp0_data = '0;
   logic        cmp1_valid = 1'b0;
   logic [3:0]  cmp1_idx = '0;
   logic [31:0] cmp1_data = '0;
   logic        flush = 1'b0;
   logic        ret_en;
   logic [5:0]  ret_preg1, ret_preg2, ret_areg1, ret_areg2;
   logic [31:0] ret_data1, ret_data2;
   logic [1:0]  ret_count;
   logic [4:0]  rob_count;
   logic        rob_empty;

   int checks = 0;
   int passes = 0;

   reorder_buffer #(.ROB_DEPTH(16), .ROB_IDX(4), .PR_SIZE(6), .AR_SIZE(6)) dut (
      .clk(clk), .rstn(rstn),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_has_dest(alloc_has_dest),
      .alloc_preg(alloc_preg), .alloc_areg(alloc_areg), .alloc_idx(alloc_idx),
      .cmp0_valid(cmp0_valid), .cmp0_idx(cmp0_idx), .cmp0_data(cmp0_data),
      .cmp1_valid(cmp1_valid), .cmp1_idx(cmp1_idx), .cmp1_data(cmp1_data),
      .flush(flush), .ret_en(ret_en),
      .ret_preg1(ret_preg1), .ret_data1(ret_data1), .ret_areg1(ret_areg1),
      .ret_preg2(ret_preg2), .ret_data2(ret_data2), .ret_areg2(ret_areg2),
      .ret_count(ret_count), .rob_count(rob_count), .rob_empty(rob_empty)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
      alloc_valid = 1'b0;
      cmp0_valid  = 1'b0;
      cmp1_valid  = 1'b0;
      flush       = 1'b0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic alloc(input logic hd, input logic [5:0] p, input logic [5:0] a);
      alloc_valid = 1'b1; alloc_has_dest = hd; alloc_preg = p; alloc_areg = a;
      step();
   endtask

   task automatic test_reset();
      #2;
      checks++; if (rob_count !== 5'd0) $display("FAIL reset_count got %0d exp 0", rob_count); else passes++;
      checks++; if (ret_en !== 1'b0) $display("FAIL reset_ret_en got %0b exp 0", ret_en); else passes++;
      checks++; if (alloc_ready !== 1'b1) $display("FAIL reset_ready got %0b exp 1", alloc_ready); else passes++;
      checks++; if (alloc_idx !== 4'd0) $display("FAIL reset_idx got %0d exp 0", alloc_idx); else passes++;
      checks++; if (rob_empty !== 1'b1) $display("FAIL reset_empty got %0b exp 1", rob_empty); else passes++;
      checks++; if (ret_preg1 !== 6'd0 || ret_data1 !== 32'd0) $display("FAIL reset_slot1 got %0d/%0h exp 0/0", ret_preg1, ret_data1); else passes++;
      @(posedge clk); #1;
      rstn = 1'b1;
   endtask

   task automatic test_alloc_and_retire();
      for (int i = 0; i < 3; i++) begin
         checks++; if (alloc_idx !== 4'(i)) $display("FAIL alloc_idx%0d got %0d exp %0d", i, alloc_idx, i); else passes++;
         alloc(1'b1, 6'(5 + i), 6'(1 + i));
      end
      checks++; if (rob_count !== 5'd3) $display("FAIL alloc_count got %0d exp 3", rob_count); else passes++;
      checks++; if (ret_en !== 1'b0) $display("FAIL alloc_no_ret got %0b exp 0", ret_en); else passes++;
      cmp0_valid = 1'b1; cmp0_idx = 4'd1; cmp0_data = 32'd22;
      step();
      checks++; if (ret_en !== 1'b0) $display("FAIL ooo_hold1 got %0b exp 0", ret_en); else passes++;
      cmp1_valid = 1'b1; cmp1_idx = 4'd0; cmp1_data = 32'd11;
      step();
      checks++; if (ret_en !== 1'b0) $display("FAIL ooo_min_latency got %0b exp 0", ret_en); else passes++;
      step();
      checks++; if (ret_en !== 1'b1 || ret_count !== 2'd2) $display("FAIL ooo_ret2 got en=%0b cnt=%0d exp 1/2", ret_en, ret_count); else passes++;
      checks++; if (ret_preg1 !== 6'd5 || ret_data1 !== 32'd11 || ret_areg1 !== 6'd1) $display("FAIL ooo_slot1 got %0d/%0d/%0d exp 5/11/1", ret_preg1, ret_data1, ret_areg1); else passes++;
      checks++; if (ret_preg2 !== 6'd6 || ret_data2 !== 32'd22 || ret_areg2 !== 6'd2) $display("FAIL ooo_slot2 got %0d/%0d/%0d exp 6/22/2", ret_preg2, ret_data2, ret_areg2); else passes++;
      checks++; if (rob_count !== 5'd1) $display("FAIL ooo_count got %0d exp 1", rob_count); else passes++;
      step();
      checks++; if (ret_en !== 1'b0 || ret_count !== 2'd0 || ret_preg1 !== 6'd0) $display("FAIL ooo_one_cycle got en=%0b cnt=%0d p1=%0d exp 0/0/0", ret_en, ret_count, ret_preg1); else passes++;
   endtask

   task automatic test_full_wrap();
      do_reset();
      for (int i = 0; i < 16; i++) alloc(1'b1, 6'(i + 1), 6'(i));
      checks++; if (alloc_ready !== 1'b0 || rob_count !== 5'd16) $display("FAIL full_state got rdy=%0b cnt=%0d exp 0/16", alloc_ready, rob_count); else passes++;
      checks++; if (alloc_idx !== 4'd0 || rob_empty !== 1'b0) $display("FAIL full_tail got idx=%0d empty=%0b exp 0/0", alloc_idx, rob_empty); else passes++;
      alloc(1'b1, 6'd63, 6'd63);
      checks++; if (rob_count !== 5'd16 || alloc_idx !== 4'd0) $display("FAIL full_ignore got cnt=%0d idx=%0d exp 16/0", rob_count, alloc_idx); else passes++;
      cmp0_valid = 1'b1; cmp0_idx = 4'd0; cmp0_data = 32'h55;
      step();
      checks++; if (ret_en !== 1'b0 || alloc_ready !== 1'b0) $display("FAIL full_cmp_edge got en=%0b rdy=%0b exp 0/0", ret_en, alloc_ready); else passes++;
      step();
      checks++; if (ret_count !== 2'd1 || ret_preg1 !== 6'd1 || ret_data1 !== 32'h55) $display("FAIL full_ret got cnt=%0d p=%0d d=%0h exp 1/1/55", ret_count, ret_preg1, ret_data1); else passes++;
      checks++; if (rob_count !== 5'd15 || alloc_ready !== 1'b1 || alloc_idx !== 4'd0) $display("FAIL full_free got cnt=%0d rdy=%0b idx=%0d exp 15/1/0", rob_count, alloc_ready, alloc_idx); else passes++;
      alloc(1'b1, 6'd33, 6'd3);
      checks++; if (alloc_idx !== 4'd1 || rob_count !== 5'd16 || alloc_ready !== 1'b0) $display("FAIL full_wrap got idx=%0d cnt=%0d rdy=%0b exp 1/16/0", alloc_idx, rob_count, alloc_ready); else passes++;
   endtask

   task automatic test_no_dest();
      do_reset();
      alloc(1'b0, 6'd9, 6'd4);
      cmp0_valid = 1'b1; cmp0_idx = 4'd0; cmp0_data = 32'h33;
      step();
      step();
      checks++; if (ret_en !== 1'b1 || ret_count !== 2'd1) $display("FAIL nodest_ret got en=%0b cnt=%0d exp 1/1", ret_en, ret_count); else passes++;
      checks++; if (ret_preg1 !== 6'd0 || ret_preg2 !== 6'd0 || ret_data1 !== 32'h33) $display("FAIL nodest_preg got p1=%0d p2=%0d d=%0h exp 0/0/33", ret_preg1, ret_preg2, ret_data1); else passes++;
   endtask

   task automatic test_port_priority();
      do_reset();
      for (int i = 0; i < 3; i++) alloc(1'b1, 6'(10 + i), 6'(7 + i));
      cmp0_valid = 1'b1; cmp0_idx = 4'd2; cmp0_data = 32'd100;
      cmp1_valid = 1'b1; cmp1_idx = 4'd2; cmp1_data = 32'd200;
      step();
      cmp0_valid = 1'b1; cmp0_idx = 4'd5; cmp0_data = 32'hdead;
      cmp1_valid = 1'b1; cmp1_idx = 4'd0; cmp1_data = 32'd1;
      step();
      checks++; if (ret_en !== 1'b0 || rob_count !== 5'd3) $display("FAIL prio_invalid got en=%0b cnt=%0d exp 0/3", ret_en, rob_count); else passes++;
      cmp0_valid = 1'b1; cmp0_idx = 4'd1; cmp0_data = 32'd2;
      step();
      checks++; if (ret_count !== 2'd1 || ret_preg1 !== 6'd10 || ret_data1 !== 32'd1) $display("FAIL prio_ret1 got cnt=%0d p=%0d d=%0d exp 1/10/1", ret_count, ret_preg1, ret_data1); else passes++;
      step();
      checks++; if (ret_count !== 2'd2 || ret_preg1 !== 6'd11 || ret_data1 !== 32'd2) $display("FAIL prio_slot1 got cnt=%0d p=%0d d=%0d exp 2/11/2", ret_count, ret_preg1, ret_data1); else passes++;
      checks++; if (ret_preg2 !== 6'd12 || ret_data2 !== 32'd100 || ret_areg2 !== 6'd9) $display("FAIL prio_port0_wins got p=%0d d=%0d a=%0d exp 12/100/9", ret_preg2, ret_data2, ret_areg2); else passes++;
      checks++; if (rob_count !== 5'd0 || rob_empty !== 1'b1) $display("FAIL prio_drain got cnt=%0d empty=%0b exp 0/1", rob_count, rob_empty); else passes++;
      cmp0_valid = 1'b1; cmp0_idx = 4'd3; cmp0_data = 32'd7;
      alloc(1'b1, 6'd13, 6'd1);
      step();
      step();
      checks++; if (ret_en !== 1'b0 || rob_count !== 5'd1 || alloc_idx !== 4'd4) $display("FAIL tail_cmp_ignored got en=%0b cnt=%0d idx=%0d exp 0/1/4", ret_en, rob_count, alloc_idx); else passes++;
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 4; i++) alloc(1'b1, 6'(1 + i), 6'(i));
      cmp0_valid = 1'b1; cmp0_idx = 4'd0; cmp0_data = 32'd5;
      cmp1_valid = 1'b1; cmp1_idx = 4'd1; cmp1_data = 32'd6;
      step();
      flush = 1'b1; alloc_valid = 1'b1; alloc_preg = 6'd20;
      #1;
      checks++; if (alloc_ready !== 1'b0) $display("FAIL flush_ready got %0b exp 0", alloc_ready); else passes++;
      step();
      checks++; if (rob_count !== 5'd0 || ret_en !== 1'b0 || alloc_idx !== 4'd0) $display("FAIL flush_state got cnt=%0d en=%0b idx=%0d exp 0/0/0", rob_count, ret_en, alloc_idx); else passes++;
      checks++; if (ret_count !== 2'd0 || ret_preg1 !== 6'd0 || rob_empty !== 1'b1) $display("FAIL flush_outs got cnt=%0d p1=%0d empty=%0b exp 0/0/1", ret_count, ret_preg1, rob_empty); else passes++;
      step();
      checks++; if (ret_en !== 1'b0 || rob_count !== 5'd0) $display("FAIL flush_after got en=%0b cnt=%0d exp 0/0", ret_en, rob_count); else passes++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      alloc(1'b1, 6'd2, 6'd2);
      alloc(1'b1, 6'd3, 6'd3);
      cmp0_valid = 1'b1; cmp0_idx = 4'd0; cmp0_data = 32'd9;
      cmp1_valid = 1'b1; cmp1_idx = 4'd1; cmp1_data = 32'd8;
      step();
      rstn = 1'b0;
      #1;
      checks++; if (rob_count !== 5'd0 || alloc_idx !== 4'd0) $display("FAIL midreset_async got cnt=%0d idx=%0d exp 0/0", rob_count, alloc_idx); else passes++;
      step();
      rstn = 1'b1;
      step();
      checks++; if (ret_en !== 1'b0 || ret_count !== 2'd0) $display("FAIL midreset_noret got en=%0b cnt=%0d exp 0/0", ret_en, ret_count); else passes++;
   endtask

   initial begin
      test_reset();
      test_alloc_and_retire();
      test_full_wrap();
      test_no_dest();
      test_port_priority();
      test_flush();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
